// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// State encodings, the NOP word, and the fetch-address fault check.
package inst_mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Misaligned byte address, or any bit set above the word-index field.
  function automatic logic fetch_fault(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/inst_mem_loader.sv
// Load/run sequencer for the instruction memory: FSM, load pointer and word count.
// state   | meaning
// IDLE    | after reset; waits for ld_start or run
// LOAD    | accepting program words into RAM from word 0 upward
// RUN     | fetches serviced; ld_start returns to LOAD
module inst_mem_loader
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic              ld_last,
  input  logic              run,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  output logic              running,
  output logic              fetch_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
        end else if (run) begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        // A restart wins over the word presented in the same cycle.
        if (ld_start) begin
          ptr_d   = '0;
          count_d = '0;
        end else if (ld_valid) begin
          wr_en   = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          count_d = count_q + (ADDR_W + 1)'(1);
          if (ld_last || (&ptr_q)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ld_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign ld_ready = (state_q == ST_LOAD);
  assign running  = (state_q == ST_RUN);
  assign fetch_en = running && !ld_start;
  assign ld_count = count_q;
  assign wr_addr  = ptr_q;

endmodule

// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory: synchronous RAM, registered 1-cycle fetch, fault and parity flags.
// Optional per-word even parity storage is enabled by defining INST_MEM_PARITY_EN.
module inst_mem_loadable
  import inst_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  input  logic              run,
  output logic              running,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              fault,
  output logic              par_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              fetch_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] fetch_idx;
  logic              addr_bad;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              fault_q, fault_d;
  logic              par_err_q, par_err_d;

  inst_mem_loader #(.ADDR_W(ADDR_W)) u_loader (
    .clk      (clk),
    .rst      (rst),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_last  (ld_last),
    .run      (run),
    .ld_ready (ld_ready),
    .ld_count (ld_count),
    .running  (running),
    .fetch_en (fetch_en),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr)
  );

  // RAM has no reset: a program survives a core reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= ld_data;
  end

`ifdef INST_MEM_PARITY_EN
  logic mem_par [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_par[wr_addr] <= ^ld_data;
  end
`endif

  assign fetch_idx = fetch_addr[ADDR_W+1:2];
  assign addr_bad  = fetch_fault(fetch_addr, ADDR_W);

  always_comb begin
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    fault_d      = 1'b0;
    par_err_d    = 1'b0;
    if (fetch_en && fetch_req) begin
      inst_valid_d = 1'b1;
      if (addr_bad) begin
        inst_d  = DATA_W'(NOP);
        fault_d = 1'b1;
      end else begin
        inst_d = mem[fetch_idx];
`ifdef INST_MEM_PARITY_EN
        par_err_d = (^mem[fetch_idx]) != mem_par[fetch_idx];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      par_err_q    <= 1'b0;
    end else begin
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
      par_err_q    <= par_err_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign fault      = fault_q;
  assign par_err    = par_err_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Self-checking bench for inst_mem_loadable against a word-array reference model.
// Parity corruption scenario is exercised only when INST_MEM_PARITY_EN is defined.
module tb_inst_mem_loadable;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ld_start = 1'b0;
  logic              ld_valid = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              ld_ready;
  logic [ADDR_W:0]   ld_count;
  logic              run = 1'b0;
  logic              running;
  logic              fetch_req = 1'b0;
  logic [31:0]       fetch_addr = '0;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              fault;
  logic              par_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] stim [DEPTH];

  always #5 clk = ~clk;

  inst_mem_loadable #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_count   (ld_count),
    .run        (run),
    .running    (running),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .inst       (inst),
    .inst_valid (inst_valid),
    .fault      (fault),
    .par_err    (par_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: a fetch faults when not word aligned or beyond the last word.
  function automatic logic model_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  function automatic logic [31:0] model_inst(input logic [31:0] a);
    if (model_fault(a)) return 32'h0;
    return model_mem[a / 4];
  endfunction

  // Streams stim[0..n-1] from a fresh ld_start, with random idle gaps.
  task automatic load_prog(input int n, input bit use_last);
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0;
        ld_data  = $urandom;
        step();
      end
      ld_valid = 1'b1;
      ld_data  = stim[i];
      ld_last  = use_last && (i == n - 1);
      step();
      model_mem[i] = stim[i];
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch_one(input logic [31:0] a, output logic [31:0] g_inst,
                           output logic g_valid, output logic g_fault, output logic g_par);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req = 1'b0;
    g_inst  = inst;
    g_valid = inst_valid;
    g_fault = fault;
    g_par   = par_err;
  endtask

  task automatic test_reset();
    logic [31:0] gi; logic gv, gf, gp;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_cmp++; if (ld_count !== '0) begin n_bad++; $display("FAIL reset_ld_count got=%0d exp=0", ld_count); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running got=%b exp=0", running); end
    n_cmp++; if (inst !== '0) begin n_bad++; $display("FAIL reset_inst got=%h exp=0", inst); end
    n_cmp++; if ({inst_valid, fault, par_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b exp=000", {inst_valid, fault, par_err}); end
    fetch_one(32'h0, gi, gv, gf, gp);
    n_cmp++; if (gv !== 1'b0) begin n_bad++; $display("FAIL idle_fetch_valid got=%b exp=0", gv); end
  endtask

  task automatic test_load_basic();
    logic [31:0] gi; logic gv, gf, gp;
    stim[0] = 32'h3c011234; stim[1] = 32'h3c025678; stim[2] = 32'h00221820;
    load_prog(3, 1'b1);
    n_cmp++; if (ld_count !== 6'd3) begin n_bad++; $display("FAIL basic_ld_count got=%0d exp=3", ld_count); end
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL basic_running got=%b exp=1", running); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ld_ready got=%b exp=0", ld_ready); end
    fetch_one(32'h4, gi, gv, gf, gp);
    n_cmp++; if (gi !== 32'h3c025678 || gv !== 1'b1 || gf !== 1'b0 || gp !== 1'b0) begin
      n_bad++; $display("FAIL basic_fetch4 got=%h/%b/%b/%b exp=3c025678/1/0/0", gi, gv, gf, gp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] last_inst;
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 32'(i * 4);
      step();
      n_cmp++; if (inst !== model_inst(32'(i * 4)) || inst_valid !== 1'b1 || fault !== 1'b0) begin
        n_bad++; $display("FAIL b2b_word%0d got=%h/%b/%b exp=%h/1/0", i, inst, inst_valid, fault, model_inst(32'(i * 4)));
      end
    end
    fetch_req = 1'b0;
    last_inst = inst;
    step();
    n_cmp++; if (inst_valid !== 1'b0 || inst !== last_inst) begin
      n_bad++; $display("FAIL hold_inst got=%h/%b exp=%h/0", inst, inst_valid, last_inst);
    end
  endtask

  task automatic test_fault();
    logic [31:0] gi, a; logic gv, gf, gp;
    fetch_one(32'h6, gi, gv, gf, gp);
    n_cmp++; if (gf !== 1'b1 || gi !== 32'h0 || gv !== 1'b1) begin n_bad++; $display("FAIL fault_0x6 got=%h/%b/%b exp=0/1/1", gi, gv, gf); end
    fetch_one(32'h80, gi, gv, gf, gp);
    n_cmp++; if (gf !== 1'b1 || gi !== 32'h0 || gv !== 1'b1) begin n_bad++; $display("FAIL fault_0x80 got=%h/%b/%b exp=0/1/1", gi, gv, gf); end
    for (int i = 0; i < 6; i++) begin
      a = (i % 2 == 0) ? (($urandom_range(0, 2) * 4) | 32'($urandom_range(1, 3)))
                       : ($urandom | 32'h0000_0080);
      fetch_one(a, gi, gv, gf, gp);
      n_cmp++; if (gf !== 1'b1 || gi !== 32'h0 || gv !== 1'b1) begin
        n_bad++; $display("FAIL fault_rand addr=%h got=%h/%b/%b exp=0/1/1", a, gi, gv, gf);
      end
    end
  endtask

  task automatic test_full_load();
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) stim[i] = $urandom;
    load_prog(DEPTH, 1'b0);
    n_cmp++; if (running !== 1'b1 || ld_ready !== 1'b0) begin n_bad++; $display("FAIL full_state got=run%b/rdy%b exp=run1/rdy0", running, ld_ready); end
    n_cmp++; if (ld_count !== 6'd32) begin n_bad++; $display("FAIL full_ld_count got=%0d exp=32", ld_count); end
    fetch_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(0, 127));
        default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      fetch_addr = a;
      step();
      n_cmp++; if (inst !== model_inst(a) || fault !== model_fault(a) || inst_valid !== 1'b1 || par_err !== 1'b0) begin
        n_bad++; $display("FAIL full_fetch addr=%h got=%h/%b/%b/%b exp=%h/1/%b/0", a, inst, inst_valid, fault, par_err, model_inst(a), model_fault(a));
      end
    end
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] gi; logic gv, gf, gp;
    for (int i = 0; i < 10; i++) stim[i] = $urandom;
    load_prog(10, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (ld_count !== '0 || running !== 1'b0 || ld_ready !== 1'b0) begin
      n_bad++; $display("FAIL midrst_state got=cnt%0d/run%b/rdy%b exp=cnt0/run0/rdy0", ld_count, running, ld_ready);
    end
    run = 1'b1;
    step();
    run = 1'b0;
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL midrst_run got=%b exp=1", running); end
    fetch_one(32'h0, gi, gv, gf, gp);
    n_cmp++; if (gi !== model_mem[0] || gv !== 1'b1) begin n_bad++; $display("FAIL midrst_word0 got=%h/%b exp=%h/1", gi, gv, model_mem[0]); end
    fetch_one(32'h7c, gi, gv, gf, gp);
    n_cmp++; if (gi !== model_mem[31] || gv !== 1'b1) begin n_bad++; $display("FAIL midrst_word31 got=%h/%b exp=%h/1", gi, gv, model_mem[31]); end
  endtask

  task automatic test_reload_during_fetch();
    logic [31:0] gi; logic gv, gf, gp;
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    ld_start   = 1'b1;
    step();
    fetch_req = 1'b0;
    ld_start  = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0 || ld_ready !== 1'b1 || ld_count !== '0) begin
      n_bad++; $display("FAIL reload_drop got=vld%b/rdy%b/cnt%0d exp=vld0/rdy1/cnt0", inst_valid, ld_ready, ld_count);
    end
    ld_valid = 1'b1;
    ld_data  = 32'hdeadbeef;
    ld_last  = 1'b1;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    model_mem[0] = 32'hdeadbeef;
    n_cmp++; if (running !== 1'b1 || ld_count !== 6'd1) begin
      n_bad++; $display("FAIL reload_state got=run%b/cnt%0d exp=run1/cnt1", running, ld_count);
    end
    fetch_one(32'h0, gi, gv, gf, gp);
    n_cmp++; if (gi !== 32'hdeadbeef || gv !== 1'b1) begin n_bad++; $display("FAIL reload_word0 got=%h/%b exp=deadbeef/1", gi, gv); end
    fetch_one(32'h8, gi, gv, gf, gp);
    n_cmp++; if (gi !== model_mem[2] || gv !== 1'b1) begin n_bad++; $display("FAIL reload_word2 got=%h/%b exp=%h/1", gi, gv, model_mem[2]); end
  endtask

  task automatic test_parity();
    logic [31:0] gi; logic gv, gf, gp;
`ifdef INST_MEM_PARITY_EN
    dut.mem[2] = dut.mem[2] ^ 32'h0000_0100;
    model_mem[2] = model_mem[2] ^ 32'h0000_0100;
    fetch_one(32'h8, gi, gv, gf, gp);
    n_cmp++; if (gp !== 1'b1 || gv !== 1'b1 || gi !== model_mem[2]) begin
      n_bad++; $display("FAIL parity_flip got=%h/vld%b/par%b exp=%h/vld1/par1", gi, gv, gp, model_mem[2]);
    end
    fetch_one(32'h4, gi, gv, gf, gp);
    n_cmp++; if (gp !== 1'b0 || gi !== model_mem[1]) begin
      n_bad++; $display("FAIL parity_clean got=%h/par%b exp=%h/par0", gi, gp, model_mem[1]);
    end
`else
    fetch_one(32'h8, gi, gv, gf, gp);
    n_cmp++; if (gp !== 1'b0 || gv !== 1'b1 || gi !== model_mem[2]) begin
      n_bad++; $display("FAIL parity_off got=%h/vld%b/par%b exp=%h/vld1/par0", gi, gv, gp, model_mem[2]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_back_to_back();
    test_fault();
    test_full_load();
    test_reset_mid_load();
    test_reload_during_fetch();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
